multi_edge_detect: RTL and testbench
====================================

# multi_edge_detect

Parametrised, multi-channel successor to the single-line D+ edge detector in the USB receiver path. Each channel does the following:
- synchronises an asynchronous serial line;
- optionally rejects glitches shorter than a programmable length;
- emits a one-cycle registered pulse on the configured edge type (rising, falling or both), with a direction bit;
- keeps a sticky per-channel edge flag that software or the decoder FSM can clear.

It sits between the raw bus pins (D+, D−, plus spare lines) and the NRZI decoder and timer logic.

## Interface
- NUM_CH, default 4: number of independent channels (≥1).
- SYNC_STAGES, default 2: synchroniser flops per channel (≥2).
- FILTER_LEN, default 3: consecutive cycles a new level must persist before it is accepted (≥1; used only with the filter compiled in).
- IDLE_VAL, default 1'b1: line idle level; reset value of every level-holding register (USB J-state idle high).

- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d_in  input  NUM_CH  asynchronous line inputs.
- mode  input  2*NUM_CH  per-channel edge select, with channel i at bits [2i+1:2i]:
  - 00: off
  - 01: rise
  - 10: fall
  - 11: both
- flag_clr  input  NUM_CH  per-channel sticky-flag clear; level-sensitive.
- level  output  NUM_CH  synchronised (and filtered) line level.
- edge_pulse  output  NUM_CH  one-cycle pulse for each qualifying edge.
- edge_dir  output  NUM_CH  1 = rising, 0 = falling; valid only while edge_pulse is high, 0 otherwise.
- edge_flag  output  NUM_CH  sticky: set by edge_pulse, cleared by flag_clr.

## Operation
- **Pipeline per channel:** sync chain → filter (optional) → previous-level register → edge qualify → registered pulse/dir → sticky flag.
- **Sync chain:** stage 1 samples d_in. The stage SYNC_STAGES output is the synced level.
- **Filter:**
  - Registers: filt (the accepted level) and cnt, of width clog2(FILTER_LEN+1).
  - If synced == filt: cnt ← 0.
  - Otherwise, if cnt == FILTER_LEN−1: filt ← synced and cnt ← 0.
  - Otherwise: cnt ← cnt+1.
  - The counter saturates by construction and never wraps.
- **Level source:** level = filt when the filter is compiled in, otherwise the synced level.
- **Edge qualify:**
  - prev ← level every cycle.
  - A rise is level & ~prev; a fall is ~level & prev.
  - qual = (rise & mode[0]) | (fall & mode[1]).
  - edge_pulse ← qual and edge_dir ← rise & qual, both registered.
- **Mode changes:** a mode change affects only edges qualified at and after the next clock. An edge that is already registered still completes its pulse.
- **Sticky flag:**
  - edge_flag ← (edge_flag & ~flag_clr) | edge_pulse.
  - If clear and a new pulse land in the same cycle, set wins and the flag stays 1.
- **Reset:**
  - All sync, filt and prev registers ← IDLE_VAL; cnt ← 0.
  - edge_pulse, edge_dir and edge_flag ← 0.
  - level reads IDLE_VAL from the first cycle after reset.
  - Reset mid-operation drops any in-flight pulse; no edge is reported on exit from reset unless the line then leaves IDLE_VAL.
- **Channel independence:** channels share no state. Simultaneous edges on several channels each produce their own pulse in the same cycle.

## Timing
- Let edge k be the first clock edge at which stage 1 samples a new d_in value.
- **No filter:**
  - level changes after edge k+SYNC_STAGES−1.
  - edge_pulse is high for exactly the cycle after edge k+SYNC_STAGES.
- **Filter compiled in:**
  - level changes after edge k+SYNC_STAGES−1+FILTER_LEN.
  - edge_pulse follows one edge later.
  - A synced-level excursion of fewer than FILTER_LEN cycles produces no level change and no pulse.
- edge_flag rises one cycle after edge_pulse. It falls the cycle after flag_clr is sampled high, provided no pulse arrives in that cycle.
- Throughput without the filter: back-to-back edges one cycle apart on the synced level each produce a pulse, so edge_pulse may be high on consecutive cycles.

## Configuration
- MULTI_EDGE_DETECT_FILTER_EN defined: the glitch filter (filt and cnt) is instantiated. FILTER_LEN applies and adds FILTER_LEN cycles of latency.
- Undefined: no filter logic; level is the synced level and FILTER_LEN is ignored.

## Structure
- **Package multi_edge_detect_pkg:**
  - typedef enum logic [1:0] edge_mode_t with values EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH.
  - Width helper constant for the filter counter.
- **Sub-module edge_det_chan:** one channel, containing sync, filter, qualify and flag. The top level is a generate loop of NUM_CH instances slicing mode.

## Test plan
1. **Reset idle.** NUM_CH=4, IDLE_VAL=1, d_in=4'hF, rst high 2 cycles then low → level=4'hF, and edge_pulse, edge_dir and edge_flag stay 0 for 10 cycles.
2. **Falling edge, both mode.** Filter off, ch0 mode=11, d_in[0] 1→0 sampled at edge k → edge_pulse[0]=1 with edge_dir[0]=0 only in the cycle after edge k+2. edge_flag[0]=1 from the next cycle on.
3. **Glitch rejection.** Filter on, FILTER_LEN=3, ch1 low pulse of 2 cycles → no pulse and level[1] stays 1. A low of 4 cycles → one pulse after edge k+2+3 (level change at edge k+4, pulse the cycle after edge k+5).
4. **Mode filtering.**
   - ch2 mode=01, line 1→0→1 → exactly one pulse, with dir=1.
   - mode=00 → no pulses.
   - mode=10 → one pulse, with dir=0.
5. **Flag set/clear collision.** flag_clr[3]=1 in the same cycle as edge_pulse[3]=1 → edge_flag[3] stays 1. flag_clr with no pulse → edge_flag[3]=0 next cycle.
6. **Reset mid-pulse.** Assert rst in the cycle edge_pulse[0]=1 → all outputs 0 next cycle, and level = IDLE_VAL regardless of d_in history.

Source files
------------

// File: rtl/multi_edge_detect_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package multi_edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  // Glitch-filter counter width: holds 0..len, never narrower than one bit.
  function automatic int unsigned filt_cnt_w(input int unsigned len);
    int unsigned w;
    w = $clog2(len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multi_edge_detect_chan.sv
// One edge-detect channel: synchroniser, optional glitch filter, qualify, sticky flag.
// Filter is compiled in only when MULTI_EDGE_DETECT_FILTER_EN is defined.
module edge_det_chan
  import multi_edge_detect_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter logic        IDLE_VAL    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_d,
  input  edge_mode_t i_mode,
  input  logic       i_flag_clr,
  output logic       o_level,
  output logic       o_edge_pulse,
  output logic       o_edge_dir,
  output logic       o_edge_flag
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;
  logic                   w_level;
  logic                   r_prev;
  logic                   r_pulse;
  logic                   r_dir;
  logic                   r_flag;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_qual;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{IDLE_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DETECT_FILTER_EN
  localparam int unsigned CNT_W = filt_cnt_w(FILTER_LEN);

  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  // A new level is accepted only after it has differed from filt for FILTER_LEN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filt <= IDLE_VAL;
      r_cnt  <= '0;
    end else if (w_synced == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == CNT_W'(FILTER_LEN - 1)) begin
      r_filt <= w_synced;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = w_synced;
`endif

  assign w_rise = w_level & ~r_prev;
  assign w_fall = ~w_level & r_prev;
  assign w_qual = (w_rise & ((i_mode == EDGE_RISE) || (i_mode == EDGE_BOTH)))
                | (w_fall & ((i_mode == EDGE_FALL) || (i_mode == EDGE_BOTH)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= IDLE_VAL;
      r_pulse <= 1'b0;
      r_dir   <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_pulse <= w_qual;
      r_dir   <= w_rise & w_qual;
      // A pulse landing together with a clear keeps the flag set.
      r_flag  <= (r_flag & ~i_flag_clr) | r_pulse;
    end
  end

  assign o_level      = w_level;
  assign o_edge_pulse = r_pulse;
  assign o_edge_dir   = r_dir;
  assign o_edge_flag  = r_flag;

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel line edge detector: NUM_CH independent edge_det_chan instances.
// Optional glitch filter enabled by defining MULTI_EDGE_DETECT_FILTER_EN.
module multi_edge_detect
  import multi_edge_detect_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter logic        IDLE_VAL    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   d_in,
  input  logic [2*NUM_CH-1:0] mode,
  input  logic [NUM_CH-1:0]   flag_clr,
  output logic [NUM_CH-1:0]   level,
  output logic [NUM_CH-1:0]   edge_pulse,
  output logic [NUM_CH-1:0]   edge_dir,
  output logic [NUM_CH-1:0]   edge_flag
);

  if (NUM_CH < 1 || SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("multi_edge_detect: NUM_CH>=1, SYNC_STAGES>=2, FILTER_LEN>=1 required");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .IDLE_VAL    (IDLE_VAL)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .i_d          (d_in[g]),
      .i_mode       (edge_mode_t'(mode[2*g +: 2])),
      .i_flag_clr   (flag_clr[g]),
      .o_level      (level[g]),
      .o_edge_pulse (edge_pulse[g]),
      .o_edge_dir   (edge_dir[g]),
      .o_edge_flag  (edge_flag[g])
    );
  end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed self-checking bench for multi_edge_detect (NUM_CH=4, SYNC_STAGES=2, FILTER_LEN=3).
module tb_multi_edge_detect;

`ifdef MULTI_EDGE_DETECT_FILTER_EN
  localparam int F = 3;
`else
  localparam int F = 0;
`endif
  localparam int LAT = 2 + F;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_in;
  logic [7:0] mode;
  logic [3:0] flag_clr;
  logic [3:0] level;
  logic [3:0] edge_pulse;
  logic [3:0] edge_dir;
  logic [3:0] edge_flag;

  int checks = 0;
  int errors = 0;

  multi_edge_detect #(
    .NUM_CH      (4),
    .SYNC_STAGES (2),
    .FILTER_LEN  (3),
    .IDLE_VAL    (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d_in       (d_in),
    .mode       (mode),
    .flag_clr   (flag_clr),
    .level      (level),
    .edge_pulse (edge_pulse),
    .edge_dir   (edge_dir),
    .edge_flag  (edge_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive channel ch low for lowlen sampled edges, then high; watch win ticks.
  task automatic run_low(input int ch, input int lowlen, input int win,
                         output int n, output int first_at, output logic fdir,
                         output logic saw_low, output int dir_bad);
    n = 0; first_at = -1; fdir = 1'b0; saw_low = 1'b0; dir_bad = 0;
    d_in[ch] = 1'b0;
    for (int t = 1; t <= win; t++) begin
      tick();
      if (edge_pulse[ch]) begin
        if (n == 0) begin
          first_at = t;
          fdir = edge_dir[ch];
        end
        n++;
      end else if (edge_dir[ch]) begin
        dir_bad++;
      end
      if (!level[ch]) saw_low = 1'b1;
      if (t == lowlen) d_in[ch] = 1'b1;
    end
  endtask

  int   n, first_at, dir_bad;
  logic fdir, saw_low;

  initial begin
    rst      = 1'b1;
    d_in     = 4'hF;
    mode     = 8'b11_01_11_11;
    flag_clr = 4'h0;

    // 1. Reset idle
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("t1_level", 32'(level), 32'hF);
    for (int i = 0; i < 10; i++) begin
      chk("t1_pulse", 32'(edge_pulse), 32'h0);
      chk("t1_dir",   32'(edge_dir),   32'h0);
      chk("t1_flag",  32'(edge_flag),  32'h0);
      tick();
    end

    // 2. Falling edge on ch0, both mode
    d_in[0] = 1'b0;
    for (int i = 0; i < LAT; i++) tick();
    chk("t2_level_changed", 32'(level), 32'hE);
    chk("t2_pulse_before",  32'(edge_pulse), 32'h0);
    tick();
    chk("t2_pulse", 32'(edge_pulse), 32'h1);
    chk("t2_dir",   32'(edge_dir),   32'h0);
    chk("t2_flag_not_yet", 32'(edge_flag), 32'h0);
    tick();
    chk("t2_pulse_after", 32'(edge_pulse), 32'h0);
    chk("t2_flag", 32'(edge_flag), 32'h1);

    // 3. Short and long low excursions on ch1
    run_low(1, 2, 12, n, first_at, fdir, saw_low, dir_bad);
    chk("t3_glitch_pulses", 32'(n), (F > 0) ? 32'd0 : 32'd2);
    chk("t3_glitch_level",  32'(saw_low), (F > 0) ? 32'd0 : 32'd1);
    run_low(1, 4, 16, n, first_at, fdir, saw_low, dir_bad);
    chk("t3_long_pulses", 32'(n), 32'd2);
    chk("t3_long_first",  32'(first_at), 32'(3 + F));
    chk("t3_long_dir",    32'(fdir), 32'd0);
    chk("t3_dir_idle",    32'(dir_bad), 32'd0);

    // 4. Mode filtering on ch2
    mode[5:4] = 2'b01;
    run_low(2, 6, 16, n, first_at, fdir, saw_low, dir_bad);
    chk("t4_rise_n",     32'(n), 32'd1);
    chk("t4_rise_at",    32'(first_at), 32'(9 + F));
    chk("t4_rise_dir",   32'(fdir), 32'd1);
    mode[5:4] = 2'b00;
    run_low(2, 6, 16, n, first_at, fdir, saw_low, dir_bad);
    chk("t4_off_n",      32'(n), 32'd0);
    mode[5:4] = 2'b10;
    run_low(2, 6, 16, n, first_at, fdir, saw_low, dir_bad);
    chk("t4_fall_n",     32'(n), 32'd1);
    chk("t4_fall_at",    32'(first_at), 32'(3 + F));
    chk("t4_fall_dir",   32'(fdir), 32'd0);
    chk("t4_dir_idle",   32'(dir_bad), 32'd0);
    chk("t4_flags",      32'(edge_flag), 32'h7);

    // 5. Flag clear colliding with a pulse on ch3
    d_in[3] = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick();
    chk("t5_pulse", 32'(edge_pulse), 32'h8);
    flag_clr = 4'hF;
    tick();
    chk("t5_collision_flag", 32'(edge_flag), 32'h8);
    tick();
    chk("t5_cleared_flag", 32'(edge_flag), 32'h0);
    flag_clr = 4'h0;
    d_in[3] = 1'b1;
    for (int i = 0; i < LAT + 3; i++) tick();
    chk("t5_reset_flag", 32'(edge_flag), 32'h8);

    // 6. Reset while a pulse is in flight on ch0
    d_in[0] = 1'b1;
    for (int i = 0; i < LAT + 1; i++) tick();
    chk("t6_pulse", 32'(edge_pulse), 32'h1);
    chk("t6_dir",   32'(edge_dir),   32'h1);
    rst  = 1'b1;
    d_in = 4'h0;
    tick();
    chk("t6_rst_pulse", 32'(edge_pulse), 32'h0);
    chk("t6_rst_dir",   32'(edge_dir),   32'h0);
    chk("t6_rst_flag",  32'(edge_flag),  32'h0);
    chk("t6_rst_level", 32'(level),      32'hF);
    d_in = 4'hF;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_post_pulse", 32'(edge_pulse), 32'h0);
      chk("t6_post_level", 32'(level),      32'hF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
